// File: rtl/regbus_sequencer.sv
// Register-file bus sequencer: READ operands onto buses a/b, EXEC captures the ALU result, WRITE drives bus c.
// Latency 2 cycles (no write-back) or 3 cycles (write-back); start is ignored unless IDLE. Optional: REGBUS_ZERO_REG_EN.
module regbus_sequencer #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_a,
  input  logic [ADDR_W-1:0] src_b,
  input  logic [ADDR_W-1:0] dst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] bus_a,
  input  logic [DATA_W-1:0] bus_b,
  input  logic [DATA_W-1:0] alu_y,
  output logic [NREG-1:0]   oe_a,
  output logic [NREG-1:0]   oe_b,
  output logic [NREG-1:0]   latch,
  output logic [DATA_W-1:0] bus_c,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_EXEC  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] src_a_q;
  logic [ADDR_W-1:0] src_b_q;
  logic [ADDR_W-1:0] dst_q;
  logic              wr_en_q;
  logic [NREG-1:0]   oe_a_q;
  logic [NREG-1:0]   oe_b_q;
  logic [NREG-1:0]   latch_q;
  logic [DATA_W-1:0] bus_c_q;
  logic [DATA_W-1:0] op_a_q;
  logic [DATA_W-1:0] op_b_q;
  logic              busy_q;
  logic              done_q;

  // Indices with no matching register decode to an all-zero vector.
  function automatic logic [NREG-1:0] onehot(input logic [ADDR_W-1:0] idx);
    logic [NREG-1:0] v;
    v = '0;
    for (int i = 0; i < NREG; i++) begin
      if (idx == ADDR_W'(i)) v[i] = 1'b1;
    end
`ifdef REGBUS_ZERO_REG_EN
    v[0] = 1'b0;
`endif
    return v;
  endfunction

  function automatic logic [DATA_W-1:0] operand(input logic [DATA_W-1:0] bus,
                                                input logic [ADDR_W-1:0] idx);
`ifdef REGBUS_ZERO_REG_EN
    return (idx == '0) ? '0 : bus;
`else
    logic unused_idx;
    unused_idx = ^idx;
    return bus;
`endif
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      src_a_q <= '0;
      src_b_q <= '0;
      dst_q   <= '0;
      wr_en_q <= 1'b0;
      oe_a_q  <= '0;
      oe_b_q  <= '0;
      latch_q <= '0;
      bus_c_q <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          latch_q <= '0;
          bus_c_q <= '0;
          done_q  <= 1'b0;
          if (start) begin
            src_a_q <= src_a;
            src_b_q <= src_b;
            dst_q   <= dst;
            wr_en_q <= wr_en;
            oe_a_q  <= onehot(src_a);
            oe_b_q  <= onehot(src_b);
            busy_q  <= 1'b1;
            state_q <= S_READ;
          end else begin
            oe_a_q  <= '0;
            oe_b_q  <= '0;
            busy_q  <= 1'b0;
          end
        end
        S_READ: begin
          op_a_q  <= operand(bus_a, src_a_q);
          op_b_q  <= operand(bus_b, src_b_q);
          oe_a_q  <= '0;
          oe_b_q  <= '0;
          done_q  <= ~wr_en_q;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          // bus_c_q doubles as the captured result: it is only ever visible in WRITE.
          if (wr_en_q) begin
            bus_c_q <= alu_y;
            latch_q <= onehot(dst_q);
            done_q  <= 1'b1;
            state_q <= S_WRITE;
          end else begin
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_WRITE: begin
          bus_c_q <= '0;
          latch_q <= '0;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          oe_a_q  <= '0;
          oe_b_q  <= '0;
          latch_q <= '0;
          bus_c_q <= '0;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign oe_a  = oe_a_q;
  assign oe_b  = oe_b_q;
  assign latch = latch_q;
  assign bus_c = bus_c_q;
  assign op_a  = op_a_q;
  assign op_b  = op_b_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule
